// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-operand hazard terms for the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_branch_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_regwrite_i,
    input  logic       ex_memread_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_memread_i,
    output logic       lu_o,
    output logic       br_o
);

    logic ex_match;
    logic mem_match;

    // x0 never carries a dependency, so a zero destination never matches.
    always_comb begin
        ex_match  = (ex_rd_i  != REG_X0) && ((ex_rd_i  == id_rs1_i) || (ex_rd_i  == id_rs2_i));
        mem_match = (mem_rd_i != REG_X0) && ((mem_rd_i == id_rs1_i) || (mem_rd_i == id_rs2_i));
        lu_o      = ex_memread_i & ex_match;
        br_o      = id_branch_i & ((ex_regwrite_i & ex_match) | (mem_memread_i & mem_match));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: start-up sequencing, hazard stalls, memory freeze, timeout error.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned WAIT_W      = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_branch_i,
    input  logic        id_taken_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_regwrite_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_memread_i,
    input  logic        mem_op_i,
    input  logic        dmem_ack_i,
    output logic        dmem_req_o,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        if_flush_o,
    output logic        id_ex_flush_o,
    output logic        pipe_hold_o,
    output logic        mem_wb_bubble_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] memwait_cnt_o,
`endif
    output logic        err_o
);

    localparam int unsigned CNT_W = (WAIT_W == 0) ? 1 : WAIT_W;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic lu;
    logic br;
    logic ms;
    logic stall;
    logic taken;
    logic active;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_branch_i   (id_branch_i),
        .ex_rd_i       (ex_rd_i),
        .ex_regwrite_i (ex_regwrite_i),
        .ex_memread_i  (ex_memread_i),
        .mem_rd_i      (mem_rd_i),
        .mem_memread_i (mem_memread_i),
        .lu_o          (lu),
        .br_o          (br)
    );

    always_comb begin
        ms     = mem_op_i & ~dmem_ack_i;
        stall  = lu | br;
        taken  = id_branch_i & id_taken_i;
        active = ~rst_i & ((state_q == RUN) | (state_q == MEM_WAIT));

        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        dmem_req_o      = 1'b0;
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        if_flush_o      = 1'b0;
        id_ex_flush_o   = 1'b0;
        pipe_hold_o     = 1'b0;
        mem_wb_bubble_o = 1'b0;
        err_o           = 1'b0;

        // Reset overrides the state outputs combinationally so a pending request drops at once.
        if (rst_i) begin
            state_d         = IDLE;
            wait_cnt_d      = '0;
            id_ex_flush_o   = 1'b1;
            mem_wb_bubble_o = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    id_ex_flush_o   = 1'b1;
                    mem_wb_bubble_o = 1'b1;
                    if (start_i) state_d = RUN;
                end
                RUN, MEM_WAIT: begin
                    dmem_req_o = mem_op_i;
                    if (ms) begin
                        pipe_hold_o     = 1'b1;
                        mem_wb_bubble_o = 1'b1;
                    end else if (stall) begin
                        id_ex_flush_o = 1'b1;
                    end else if (taken) begin
                        pc_write_o    = 1'b1;
                        if_id_write_o = 1'b1;
                        if_flush_o    = 1'b1;
                    end else begin
                        pc_write_o    = 1'b1;
                        if_id_write_o = 1'b1;
                    end

                    if (state_q == RUN) begin
                        if (ms) begin
                            state_d    = MEM_WAIT;
                            wait_cnt_d = '0;
                        end
                    end else if (!ms) begin
                        state_d = RUN;
                    end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                        state_d = ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                ERR: begin
                    err_o           = 1'b1;
                    pipe_hold_o     = 1'b1;
                    mem_wb_bubble_o = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] memwait_cnt_q, memwait_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (active && !ms && stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (if_flush_o && (flush_cnt_q != '1))              flush_cnt_d = flush_cnt_q + 32'd1;
        if (active && ms && (memwait_cnt_q != '1))          memwait_cnt_d = memwait_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       tk;
        logic [4:0] exrd;
        logic       exrw;
        logic       exmr;
        logic [4:0] memrd;
        logic       memmr;
        logic       memop;
        logic       ack;
    } in_t;

    typedef struct {
        logic [7:0] e;
        logic [7:0] m;
        string      nm;
    } exp_t;

    // Output vector: {err, req, pc_write, if_id_write, if_flush, id_ex_flush, pipe_hold, mem_wb_bubble}
    localparam logic [7:0] O_IDLE   = 8'h05;
    localparam logic [7:0] O_NORM   = 8'h30;
    localparam logic [7:0] O_NORMRQ = 8'h70;
    localparam logic [7:0] O_STALL  = 8'h04;
    localparam logic [7:0] O_STALLR = 8'h44;
    localparam logic [7:0] O_TAKEN  = 8'h38;
    localparam logic [7:0] O_FREEZE = 8'h43;
    localparam logic [7:0] O_ERR    = 8'h82;
    localparam logic [7:0] M_ALL    = 8'hFF;
    localparam logic [7:0] M_ERR    = 8'hFE;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [4:0] id_rs1_i = '0;
    logic [4:0] id_rs2_i = '0;
    logic       id_branch_i = 1'b0;
    logic       id_taken_i = 1'b0;
    logic [4:0] ex_rd_i = '0;
    logic       ex_regwrite_i = 1'b0;
    logic       ex_memread_i = 1'b0;
    logic [4:0] mem_rd_i = '0;
    logic       mem_memread_i = 1'b0;
    logic       mem_op_i = 1'b0;
    logic       dmem_ack_i = 1'b0;
    logic       dmem_req_o, pc_write_o, if_id_write_o, if_flush_o;
    logic       id_ex_flush_o, pipe_hold_o, mem_wb_bubble_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic pend = 1'b0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_branch_i     (id_branch_i),
        .id_taken_i      (id_taken_i),
        .ex_rd_i         (ex_rd_i),
        .ex_regwrite_i   (ex_regwrite_i),
        .ex_memread_i    (ex_memread_i),
        .mem_rd_i        (mem_rd_i),
        .mem_memread_i   (mem_memread_i),
        .mem_op_i        (mem_op_i),
        .dmem_ack_i      (dmem_ack_i),
        .dmem_req_o      (dmem_req_o),
        .pc_write_o      (pc_write_o),
        .if_id_write_o   (if_id_write_o),
        .if_flush_o      (if_flush_o),
        .id_ex_flush_o   (id_ex_flush_o),
        .pipe_hold_o     (pipe_hold_o),
        .mem_wb_bubble_o (mem_wb_bubble_o),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
        .memwait_cnt_o   (memwait_cnt_o),
`endif
        .err_o           (err_o)
    );

    // A request must keep mem_op_i asserted until it is acknowledged.
    always @(posedge clk_i) begin
        if (rst_i) pend <= 1'b0;
        else       pend <= dmem_req_o & ~dmem_ack_i;
    end

    always @(negedge clk_i) begin
        if (pend && !rst_i) begin
            assert (mem_op_i) else $error("mem_op_i dropped before ack");
        end
    end

    // Monitor: the DUT presents a full output vector every cycle; compare against the queued expectation.
    always @(negedge clk_i) begin
        logic [7:0] act;
        exp_t       x;
        if (sb_q.size() > 0) begin
            x   = sb_q.pop_front();
            act = {err_o, dmem_req_o, pc_write_o, if_id_write_o,
                   if_flush_o, id_ex_flush_o, pipe_hold_o, mem_wb_bubble_o};
            checks++;
            if ((act & x.m) !== (x.e & x.m)) begin
                failures++;
                $display("FAIL %s: got %b expected %b (mask %b)", x.nm, act, x.e, x.m);
            end
        end
    end

    task automatic cyc(input in_t v, input logic [7:0] e, input logic [7:0] m, input string nm);
        exp_t x;
        @(posedge clk_i);
        #1;
        rst_i         = v.rst;
        start_i       = v.start;
        id_rs1_i      = v.rs1;
        id_rs2_i      = v.rs2;
        id_branch_i   = v.br;
        id_taken_i    = v.tk;
        ex_rd_i       = v.exrd;
        ex_regwrite_i = v.exrw;
        ex_memread_i  = v.exmr;
        mem_rd_i      = v.memrd;
        mem_memread_i = v.memmr;
        mem_op_i      = v.memop;
        dmem_ack_i    = v.ack;
        x.e  = e;
        x.m  = m;
        x.nm = nm;
        sb_q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;
        in_t z;
        z = '0;

        v = z; v.rst = 1'b1;
        cyc(v, O_IDLE, M_ALL, "reset0");
        cyc(v, O_IDLE, M_ALL, "reset1");
        v = z; v.start = 1'b1;
        cyc(v, O_IDLE, M_ALL, "idle_start");
        cyc(z, O_NORM, M_ALL, "run_first");
        v = z; v.start = 1'b1;
        cyc(v, O_NORM, M_ALL, "start_in_run");

        v = z; v.exmr = 1'b1; v.exrd = 5'd5; v.rs2 = 5'd5;
        cyc(v, O_STALL, M_ALL, "lu_stall");
        cyc(z, O_NORM, M_ALL, "lu_release");
        v = z; v.exmr = 1'b1;
        cyc(v, O_NORM, M_ALL, "lu_x0");
        v = z; v.exrw = 1'b1; v.exrd = 5'd3; v.rs1 = 5'd3;
        cyc(v, O_NORM, M_ALL, "alu_no_branch");

        v = z; v.br = 1'b1; v.tk = 1'b1; v.rs1 = 5'd3; v.exrw = 1'b1; v.exrd = 5'd3;
        cyc(v, O_STALL, M_ALL, "br_stall");
        v = z; v.br = 1'b1; v.tk = 1'b1; v.rs1 = 5'd3;
        cyc(v, O_TAKEN, M_ALL, "br_taken");
        cyc(z, O_NORM, M_ALL, "br_after");
        v = z; v.br = 1'b1; v.rs2 = 5'd7; v.memmr = 1'b1; v.memrd = 5'd7;
        cyc(v, O_STALL, M_ALL, "br_mem_stall");
        v = z; v.br = 1'b1; v.rs2 = 5'd7; v.memrd = 5'd7;
        cyc(v, O_NORM, M_ALL, "br_not_taken");

        v = z; v.memop = 1'b1;
        cyc(v, O_FREEZE, M_ALL, "mem_freeze0");
        for (int i = 1; i < 4; i++) cyc(v, O_FREEZE, M_ALL, "mem_freeze");
        v.ack = 1'b1;
        cyc(v, O_NORMRQ, M_ALL, "mem_ack");
        cyc(z, O_NORM, M_ALL, "mem_after");
        v = z; v.ack = 1'b1;
        cyc(v, O_NORM, M_ALL, "stray_ack");
        v = z; v.memop = 1'b1; v.ack = 1'b1;
        cyc(v, O_NORMRQ, M_ALL, "mem_fast");
        cyc(z, O_NORM, M_ALL, "mem_fast_after");

        v = z; v.memop = 1'b1; v.exmr = 1'b1; v.exrd = 5'd5; v.rs1 = 5'd5; v.br = 1'b1; v.tk = 1'b1;
        cyc(v, O_FREEZE, M_ALL, "combo_freeze0");
        cyc(v, O_FREEZE, M_ALL, "combo_freeze1");
        cyc(v, O_FREEZE, M_ALL, "combo_freeze2");
        v.ack = 1'b1;
        cyc(v, O_STALLR, M_ALL, "combo_ack_stall");
        v = z; v.br = 1'b1; v.tk = 1'b1; v.rs1 = 5'd5;
        cyc(v, O_TAKEN, M_ALL, "combo_flush");
        cyc(z, O_NORM, M_ALL, "combo_after");

        v = z; v.memop = 1'b1;
        cyc(v, O_FREEZE, M_ALL, "to_freeze");
        for (int i = 0; i < 4; i++) cyc(v, O_FREEZE, M_ALL, "to_wait");
        cyc(v, O_ERR, M_ERR, "err0");
        v.start = 1'b1;
        cyc(v, O_ERR, M_ERR, "err_start");
        v = z; v.memop = 1'b1; v.ack = 1'b1;
        cyc(v, O_ERR, M_ERR, "err_ack");
        v = z; v.memop = 1'b1; v.rst = 1'b1;
        cyc(v, O_IDLE, M_ALL, "err_reset");
        cyc(z, O_IDLE, M_ALL, "idle_after_err");

        v = z; v.start = 1'b1;
        cyc(v, O_IDLE, M_ALL, "restart");
        v = z; v.memop = 1'b1;
        cyc(v, O_FREEZE, M_ALL, "rst_wait_freeze0");
        cyc(v, O_FREEZE, M_ALL, "rst_wait_freeze1");
        v.rst = 1'b1;
        cyc(v, O_IDLE, M_ALL, "rst_mid_wait");
        cyc(z, O_IDLE, M_ALL, "idle_after_rst");

        @(posedge clk_i);
        @(posedge clk_i);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
